// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier; the ALU control unit
// also imports this to decode the multiplier state and busy handshake.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } mult_state_t;

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   function automatic int mult_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_sign_adjust.sv
// Conditional two's-complement: passes the value through or negates it.
// Used both for operand magnitudes and for re-signing the final product.
module mult_sign_adjust
   import mult_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = value;
      if (negate) begin
         result = ~value + WIDTH'(1);
      end
   end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned, one iteration per cycle
// with busy/done handshake and early completion on a zero operand.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = mult_cnt_width(WIDTH)
) (
   input  logic                 clockMul,
   input  logic                 resetMul,
   input  logic                 start,
   input  logic                 signedMode,
   input  logic [WIDTH-1:0]     mult1,
   input  logic [WIDTH-1:0]     mult2,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   produto
);

   mult_state_t          state;
   logic [CNT_W-1:0]     count;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mcand;
   logic                 neg_en;
   logic                 sign_raw;

   logic [WIDTH-1:0]     mag1;
   logic [WIDTH-1:0]     mag2;
   logic                 zero_op;
   logic [2*WIDTH-1:0]   prod_adj;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH:0]     step;

   mult_sign_adjust #(.WIDTH(WIDTH)) u_mag1 (
      .value  (mult1),
      .negate (signedMode & mult1[WIDTH-1]),
      .result (mag1)
   );

   mult_sign_adjust #(.WIDTH(WIDTH)) u_mag2 (
      .value  (mult2),
      .negate (signedMode & mult2[WIDTH-1]),
      .result (mag2)
   );

   mult_sign_adjust #(.WIDTH(2*WIDTH)) u_result (
      .value  (acc),
      .negate (neg_en & sign_raw),
      .result (prod_adj)
   );

   assign zero_op = (mag1 == '0) || (mag2 == '0);

   // Add and shift merged: the carry out of the upper-half add becomes the
   // top bit of the {carry, reg} word before the right shift.
   always_comb begin
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      step = {sum, acc[WIDTH-1:0]};
   end

   always_ff @(posedge clockMul) begin
      if (resetMul) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         produto  <= '0;
         count    <= '0;
         acc      <= '0;
         mcand    <= '0;
         neg_en   <= 1'b0;
         sign_raw <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  neg_en   <= signedMode;
                  sign_raw <= mult1[WIDTH-1] ^ mult2[WIDTH-1];
                  mcand    <= mag1;
                  acc      <= zero_op ? '0 : {{WIDTH{1'b0}}, mag2};
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= zero_op ? FINISH : RUN;
               end
            end
            RUN: begin
               acc   <= step[2*WIDTH:1];
               count <= count + CNT_W'(1);
               if (count == CNT_W'(WIDTH - 1)) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               produto <= prod_adj;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=16 and WIDTH=8.
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   logic        s16, sm16, busy16, done16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic        s8, sm8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   typedef struct {
      logic [31:0] p;
      int          lat;
      int          t0;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];
   exp_t e16, e8;
   int   n_done16 = 0;
   int   prev_done = 0;
   int   last_done = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_multiplier #(.WIDTH(16)) dut16 (
      .clockMul(clk), .resetMul(rst), .start(s16), .signedMode(sm16),
      .mult1(a16), .mult2(b16), .busy(busy16), .done(done16), .produto(p16)
   );

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clockMul(clk), .resetMul(rst), .start(s8), .signedMode(sm8),
      .mult1(a8), .mult2(b8), .busy(busy8), .done(done8), .produto(p8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic sm);
      logic signed [31:0] sa, sb;
      if (sm) begin
         sa = {{16{a[15]}}, a};
         sb = {{16{b[15]}}, b};
         return sa * sb;
      end
      return {16'h0, a} * {16'h0, b};
   endfunction

   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
      logic signed [15:0] sa, sb;
      if (sm) begin
         sa = {{8{a[7]}}, a};
         sb = {{8{b[7]}}, b};
         return sa * sb;
      end
      return {8'h0, a} * {8'h0, b};
   endfunction

   always @(negedge clk) begin
      if (done16) begin
         n_done16++;
         prev_done = last_done;
         last_done = cyc;
         if (q16.size() == 0) begin
            chk("unexp_done16", 64'(done16), 64'd0);
         end else begin
            e16 = q16.pop_front();
            chk("prod16", 64'(p16), 64'(e16.p));
            chk("lat16", 64'(cyc - e16.t0), 64'(e16.lat));
         end
      end
      if (done8) begin
         if (q8.size() == 0) begin
            chk("unexp_done8", 64'(done8), 64'd0);
         end else begin
            e8 = q8.pop_front();
            chk("prod8", 64'(p8), 64'(e8.p[15:0]));
            chk("lat8", 64'(cyc - e8.t0), 64'(e8.lat));
         end
      end
   end

   // Drive at a negedge; returns #1 after the accepting edge.
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic push);
      exp_t e;
      a16 = a; b16 = b; sm16 = sm; s16 = 1'b1;
      @(posedge clk);
      #1;
      s16 = 1'b0;
      e.p   = ref16(a, b, sm);
      e.lat = (a == 16'h0 || b == 16'h0) ? 1 : 17;
      e.t0  = cyc;
      if (push) q16.push_back(e);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm);
      exp_t e;
      a8 = a; b8 = b; sm8 = sm; s8 = 1'b1;
      @(posedge clk);
      #1;
      s8 = 1'b0;
      e.p   = {16'h0, ref8(a, b, sm)};
      e.lat = (a == 8'h0 || b == 8'h0) ? 1 : 9;
      e.t0  = cyc;
      q8.push_back(e);
   endtask

   task automatic drain16();
      for (int i = 0; i < 200 && q16.size() != 0; i++) @(negedge clk);
      if (q16.size() != 0) begin
         chk("timeout16", 64'(q16.size()), 64'd0);
         q16.delete();
      end
   endtask

   task automatic drain8();
      for (int i = 0; i < 200 && q8.size() != 0; i++) @(negedge clk);
      if (q8.size() != 0) begin
         chk("timeout8", 64'(q8.size()), 64'd0);
         q8.delete();
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nd;
      int i;
      logic [15:0] ra, rb;
      rst = 1'b1;
      s16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
      s8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy16", 64'(busy16), 64'd0);
      chk("rst_done16", 64'(done16), 64'd0);
      chk("rst_prod16", 64'(p16), 64'd0);
      chk("rst_prod8", 64'(p8), 64'd0);
      rst = 1'b0;

      // Unsigned max with cycle-by-cycle busy/done tracking
      @(negedge clk);
      op16(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      chk("busy_start", 64'(busy16), 64'd1);
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         chk("busy_run", 64'(busy16), 64'd1);
         chk("done_early", 64'(done16), 64'd0);
      end
      @(posedge clk);
      #1;
      chk("busy_end", 64'(busy16), 64'd0);
      chk("done_end", 64'(done16), 64'd1);
      chk("umax_prod", 64'(p16), 64'hFFFE0001);
      @(posedge clk);
      #1;
      chk("done_pulse", 64'(done16), 64'd0);
      chk("prod_hold", 64'(p16), 64'hFFFE0001);
      drain16();

      // Signed cases
      @(negedge clk); op16(16'hFFFD, 16'h0005, 1'b1, 1'b1); drain16();
      @(negedge clk); op16(16'h8000, 16'h8000, 1'b1, 1'b1); drain16();
      @(negedge clk); op16(16'h8000, 16'h0001, 1'b1, 1'b1); drain16();

      // Zero skip then a normal op
      @(negedge clk); op16(16'h0000, 16'h1234, 1'b0, 1'b1); drain16();
      @(negedge clk); op16(16'h0000, 16'h1234, 1'b1, 1'b1); drain16();
      @(negedge clk); op16(16'h0007, 16'h0006, 1'b0, 1'b1); drain16();

      // Start pulse mid-RUN must be ignored
      nd = n_done16;
      @(negedge clk); op16(16'h1234, 16'h5678, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      a16 = 16'hAAAA; b16 = 16'h0005; s16 = 1'b1;
      @(posedge clk);
      #1;
      s16 = 1'b0;
      drain16();
      repeat (25) @(negedge clk);
      chk("ignored_start", 64'(n_done16 - nd), 64'd1);

      // Back-to-back: start held in the done cycle
      @(negedge clk); op16(16'd100, 16'd200, 1'b0, 1'b1);
      for (i = 0; i < 40 && !done16; i++) @(negedge clk);
      chk("b2b_done_seen", 64'(done16), 64'd1);
      op16(16'hFFFF, 16'h0002, 1'b1, 1'b1);
      drain16();
      chk("b2b_gap", 64'(last_done - prev_done), 64'd18);

      // Reset at RUN iteration 8
      @(negedge clk);
      nd = n_done16;
      op16(16'h1234, 16'h5678, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_busy", 64'(busy16), 64'd0);
      chk("mid_rst_done", 64'(done16), 64'd0);
      chk("mid_rst_prod", 64'(p16), 64'd0);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      chk("mid_rst_nodone", 64'(n_done16 - nd), 64'd0);
      @(negedge clk); op16(16'd3, 16'd4, 1'b0, 1'b1); drain16();

      // Random regression, WIDTH=16
      for (int m = 0; m < 2; m++) begin
         for (int n = 0; n < 250; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ra = '0;
            if ($urandom_range(0, 15) == 0) rb = 16'h8000;
            @(negedge clk); op16(ra, rb, m[0], 1'b1); drain16();
         end
      end

      // WIDTH=8 directed and random
      @(negedge clk); op8(8'hFF, 8'hFF, 1'b0); drain8();
      @(negedge clk); op8(8'h80, 8'h80, 1'b1); drain8();
      @(negedge clk); op8(8'h00, 8'h12, 1'b1); drain8();
      for (int m = 0; m < 2; m++) begin
         for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            op8(8'($urandom), 8'($urandom), m[0]);
            drain8();
         end
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
